// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipe_hazard_ctrl: RAW-hazard stall, multi-cycle memory-write hold and  |
// | halt drain/park sequencer for the 6-bit mini-core pipeline.            |
// | Optional: define PIPE_FWD_EN when the ALU stage forwards to decode.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int ADDR_W       = 6,
  parameter int MEM_WR_LAT   = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_src_1,
  input  logic [ADDR_W-1:0] dec_src_2,
  input  logic              dec_uses_2,
  input  logic              dec_is_halt,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_write_adr,
  input  logic              ld_writes_reg,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_write_adr,
  input  logic              ex_writes_reg,
  input  logic              mem_wr_req,
  output logic              freeze_front,
  output logic              freeze,
  output logic              ld_inst_halt,
  output logic              halted,
  output logic [2:0]        state,
  output logic [7:0]        stall_cnt
);

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_MEM_BUSY = 3'd1,
    S_DRAIN    = 3'd2,
    S_HALTED   = 3'd3
  } state_t;

  localparam logic       C_MEM_MULTI  = 1'(MEM_WR_LAT > 1);
  localparam logic [7:0] C_MEM_LOAD   = 8'(MEM_WR_LAT - 2);
  localparam logic [7:0] C_WR_EXTRA   = 8'(MEM_WR_LAT - 1);
  localparam logic [7:0] C_DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_wcnt, w_wcnt_nxt;
  logic       r_halted;
  logic [7:0] r_stall_cnt;
  logic       w_stall_inc;
  logic       w_haz_ld, w_haz_ex, w_haz;

  assign w_haz_ld = dec_valid & ld_valid & ld_writes_reg &
                    ((dec_src_1 == ld_write_adr) | (dec_uses_2 & (dec_src_2 == ld_write_adr)));
  assign w_haz_ex = dec_valid & ex_valid & ex_writes_reg &
                    ((dec_src_1 == ex_write_adr) | (dec_uses_2 & (dec_src_2 == ex_write_adr)));

`ifdef PIPE_FWD_EN
  logic w_haz_ex_unused;
  assign w_haz_ex_unused = w_haz_ex;
  assign w_haz           = w_haz_ld;
`else
  assign w_haz = w_haz_ld | w_haz_ex;
`endif

  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = r_cnt;
    w_wcnt_nxt   = r_wcnt;
    w_stall_inc  = 1'b0;
    freeze       = 1'b0;
    freeze_front = 1'b0;
    ld_inst_halt = 1'b0;
    case (r_state)
      S_RUN: begin
        if (mem_wr_req && C_MEM_MULTI) begin
          freeze_front = 1'b1;
          ld_inst_halt = 1'b1;
          w_cnt_nxt    = C_MEM_LOAD;
          w_next       = S_MEM_BUSY;
        end else if (w_haz) begin
          freeze_front = 1'b1;
          ld_inst_halt = 1'b1;
          w_stall_inc  = 1'b1;
        end else if (dec_valid && dec_is_halt) begin
          freeze_front = 1'b1;
          ld_inst_halt = 1'b1;
          w_cnt_nxt    = C_DRAIN_LOAD;
          w_wcnt_nxt   = 8'd0;
          w_next       = S_DRAIN;
        end
      end
      S_MEM_BUSY: begin
        freeze       = 1'b1;
        freeze_front = 1'b1;
        ld_inst_halt = 1'b1;
        if (r_cnt == 8'd0) w_next = S_RUN;
        else               w_cnt_nxt = r_cnt - 8'd1;
      end
      S_DRAIN: begin
        freeze_front = 1'b1;
        ld_inst_halt = 1'b1;
        // A write issued while draining pauses the drain count until it completes.
        if (r_wcnt != 8'd0) begin
          freeze     = 1'b1;
          w_wcnt_nxt = r_wcnt - 8'd1;
        end else if (mem_wr_req && C_MEM_MULTI) begin
          w_wcnt_nxt = C_WR_EXTRA;
        end else if (r_cnt == 8'd0) begin
          w_next = S_HALTED;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_HALTED: begin
        freeze       = 1'b1;
        freeze_front = 1'b1;
        ld_inst_halt = 1'b1;
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_cnt       <= 8'd0;
      r_wcnt      <= 8'd0;
      r_halted    <= 1'b0;
      r_stall_cnt <= 8'd0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_halted <= r_halted | (w_next == S_HALTED);
      if (w_stall_inc && (r_stall_cnt != 8'hFF))
        r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  assign state     = r_state;
  assign halted    = r_halted;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl: directed vector bench for pipe_hazard_ctrl         |
// | (MEM_WR_LAT=3, DRAIN_CYCLES=3). Revision: 1.0                           |
// +------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       dec_valid, dec_uses_2, dec_is_halt;
  logic [5:0] dec_src_1, dec_src_2;
  logic       ld_valid, ld_writes_reg;
  logic [5:0] ld_write_adr;
  logic       ex_valid, ex_writes_reg;
  logic [5:0] ex_write_adr;
  logic       mem_wr_req;
  logic       freeze_front, freeze, ld_inst_halt, halted;
  logic [2:0] state;
  logic [7:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.ADDR_W(6), .MEM_WR_LAT(3), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_src_1(dec_src_1), .dec_src_2(dec_src_2),
    .dec_uses_2(dec_uses_2), .dec_is_halt(dec_is_halt),
    .ld_valid(ld_valid), .ld_write_adr(ld_write_adr), .ld_writes_reg(ld_writes_reg),
    .ex_valid(ex_valid), .ex_write_adr(ex_write_adr), .ex_writes_reg(ex_writes_reg),
    .mem_wr_req(mem_wr_req),
    .freeze_front(freeze_front), .freeze(freeze), .ld_inst_halt(ld_inst_halt),
    .halted(halted), .state(state), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n, dv, u2, hlt, lv, lw, ev, ew, mw;
    logic [5:0] s1, s2, la, ea;
    logic       e_frz, e_ff, e_lih, e_hlt;
    logic [2:0] e_st;
    logic [7:0] e_sc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic r, input logic dv,
                              input logic [5:0] s1, input logic [5:0] s2, input logic u2,
                              input logic hlt, input logic lv, input logic [5:0] la,
                              input logic lw, input logic ev, input logic [5:0] ea,
                              input logic ew, input logic mw, input logic efrz,
                              input logic eff, input logic elih, input logic [2:0] est,
                              input logic ehlt, input int esc);
    vec_t v;
    v.name = n; v.rst_n = r; v.dv = dv; v.s1 = s1; v.s2 = s2; v.u2 = u2; v.hlt = hlt;
    v.lv = lv; v.la = la; v.lw = lw; v.ev = ev; v.ea = ea; v.ew = ew; v.mw = mw;
    v.e_frz = efrz; v.e_ff = eff; v.e_lih = elih; v.e_st = est; v.e_hlt = ehlt;
    v.e_sc = 8'(esc);
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic dv, input logic [5:0] s1, input logic [5:0] s2,
                       input logic u2, input logic hlt, input logic lv, input logic [5:0] la,
                       input logic lw, input logic ev, input logic [5:0] ea, input logic ew,
                       input logic mw);
    rst_n = r; dec_valid = dv; dec_src_1 = s1; dec_src_2 = s2; dec_uses_2 = u2;
    dec_is_halt = hlt; ld_valid = lv; ld_write_adr = la; ld_writes_reg = lw;
    ex_valid = ev; ex_write_adr = ea; ex_writes_reg = ew; mem_wr_req = mw;
  endtask

  task automatic idle(input logic r);
    drive(r, 0, 6'd0, 6'd0, 0, 0, 0, 6'd0, 0, 0, 6'd0, 0, 0);
  endtask

  initial begin
    int sc_ex;
    logic ff_ex;
`ifdef PIPE_FWD_EN
    ff_ex = 1'b0; sc_ex = 1;
`else
    ff_ex = 1'b1; sc_ex = 2;
`endif
    //             name         r dv s1    s2    u2 h lv la    lw ev ea    ew mw frz ff lih st h sc
    tbl.push_back(mk("reset",    0,0,6'd0, 6'd0, 0,0,0,6'd0, 0,0,6'd0, 0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("idle",     1,0,6'd0, 6'd0, 0,0,0,6'd0, 0,0,6'd0, 0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("haz_ld",   1,1,6'd5, 6'd0, 0,0,1,6'd5, 1,0,6'd0, 0,0, 0,1,1, 0,0,1));
    tbl.push_back(mk("idle2",    1,0,6'd0, 6'd0, 0,0,0,6'd0, 0,0,6'd0, 0,0, 0,0,0, 0,0,1));
    tbl.push_back(mk("haz_ex_s2",1,1,6'd1, 6'd9, 1,0,0,6'd0, 0,1,6'd9, 1,0, 0,ff_ex,ff_ex, 0,0,sc_ex));
    tbl.push_back(mk("no_use2",  1,1,6'd1, 6'd5, 0,0,1,6'd5, 1,0,6'd0, 0,0, 0,0,0, 0,0,sc_ex));
    tbl.push_back(mk("no_wr_reg",1,1,6'd5, 6'd0, 0,0,1,6'd5, 0,0,6'd0, 0,0, 0,0,0, 0,0,sc_ex));
    tbl.push_back(mk("haz_adr0", 1,1,6'd0, 6'd0, 0,0,1,6'd0, 1,0,6'd0, 0,0, 0,1,1, 0,0,sc_ex+1));
    tbl.push_back(mk("mem_req",  1,1,6'd5, 6'd0, 0,0,1,6'd5, 1,0,6'd0, 0,1, 0,1,1, 1,0,sc_ex+1));
    tbl.push_back(mk("mem_busy1",1,1,6'd5, 6'd0, 0,0,1,6'd5, 1,0,6'd0, 0,1, 1,1,1, 1,0,sc_ex+1));
    tbl.push_back(mk("mem_busy2",1,1,6'd5, 6'd0, 0,0,1,6'd5, 1,0,6'd0, 0,1, 1,1,1, 0,0,sc_ex+1));
    tbl.push_back(mk("after_mem",1,0,6'd0, 6'd0, 0,0,0,6'd0, 0,0,6'd0, 0,0, 0,0,0, 0,0,sc_ex+1));
    tbl.push_back(mk("halt_dec", 1,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 2,0,sc_ex+1));
    tbl.push_back(mk("drain1",   1,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 2,0,sc_ex+1));
    tbl.push_back(mk("drain2haz",1,1,6'd5, 6'd0, 0,1,1,6'd5, 1,0,6'd0, 0,0, 0,1,1, 2,0,sc_ex+1));
    tbl.push_back(mk("drain3",   1,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 3,1,sc_ex+1));
    tbl.push_back(mk("halted",   1,0,6'd0, 6'd0, 0,0,0,6'd0, 0,0,6'd0, 0,0, 1,1,1, 3,1,sc_ex+1));
    tbl.push_back(mk("halted_mw",1,1,6'd5, 6'd0, 0,0,1,6'd5, 1,0,6'd0, 0,1, 1,1,1, 3,1,sc_ex+1));
    tbl.push_back(mk("rst_halt", 0,0,6'd0, 6'd0, 0,0,0,6'd0, 0,0,6'd0, 0,0, 1,1,1, 0,0,0));
    tbl.push_back(mk("idle3",    1,0,6'd0, 6'd0, 0,0,0,6'd0, 0,0,6'd0, 0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk("halt_b",   1,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 2,0,0));
    tbl.push_back(mk("drain_b1", 1,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 2,0,0));
    tbl.push_back(mk("rst_drain",0,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 0,0,0));
    tbl.push_back(mk("halt_c",   1,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 2,0,0));
    tbl.push_back(mk("drain_c1", 1,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 2,0,0));
    tbl.push_back(mk("drain_c2", 1,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 2,0,0));
    tbl.push_back(mk("drain_c3", 1,1,6'd0, 6'd0, 0,1,0,6'd0, 0,0,6'd0, 0,0, 0,1,1, 3,1,0));

    idle(0);
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].dv, tbl[i].s1, tbl[i].s2, tbl[i].u2, tbl[i].hlt,
            tbl[i].lv, tbl[i].la, tbl[i].lw, tbl[i].ev, tbl[i].ea, tbl[i].ew, tbl[i].mw);
      #1;
      check({tbl[i].name, ".freeze"},       {7'd0, freeze},       {7'd0, tbl[i].e_frz});
      check({tbl[i].name, ".freeze_front"}, {7'd0, freeze_front}, {7'd0, tbl[i].e_ff});
      check({tbl[i].name, ".ld_inst_halt"}, {7'd0, ld_inst_halt}, {7'd0, tbl[i].e_lih});
      @(posedge clk);
      #1;
      check({tbl[i].name, ".state"},     {5'd0, state},      {5'd0, tbl[i].e_st});
      check({tbl[i].name, ".halted"},    {7'd0, halted},     {7'd0, tbl[i].e_hlt});
      check({tbl[i].name, ".stall_cnt"}, stall_cnt,          tbl[i].e_sc);
    end

    // Memory write during DRAIN: request cycle free, then two frozen cycles.
    @(negedge clk); idle(0);
    @(negedge clk); drive(1, 1, 6'd0, 6'd0, 0, 1, 0, 6'd0, 0, 0, 6'd0, 0, 0);
    @(negedge clk); drive(1, 0, 6'd0, 6'd0, 0, 0, 0, 6'd0, 0, 0, 6'd0, 0, 1);
    #1 check("drain_wr.req_freeze", {7'd0, freeze}, 8'd0);
    @(negedge clk); idle(1);
    #1 check("drain_wr.hold1", {7'd0, freeze}, 8'd1);
    @(negedge clk);
    #1 check("drain_wr.hold2", {7'd0, freeze}, 8'd1);
    @(negedge clk);
    #1 check("drain_wr.resume", {7'd0, freeze}, 8'd0);
    check("drain_wr.still_drain", {5'd0, state}, 8'd2);
    begin
      int k = 0;
      while (!halted && k < 10) begin
        @(posedge clk); #1; k++;
      end
      check("drain_wr.reached_halted", {7'd0, halted}, 8'd1);
    end

    // Stall counter saturation.
    @(negedge clk); idle(0);
    @(negedge clk); drive(1, 1, 6'd7, 6'd0, 0, 0, 1, 6'd7, 1, 0, 6'd0, 0, 0);
    repeat (260) @(posedge clk);
    #1;
    check("sat.stall_cnt", stall_cnt, 8'd255);
    check("sat.freeze_front", {7'd0, freeze_front}, 8'd1);
    check("sat.state", {5'd0, state}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/halt sequencer for the 6-bit mini-core pipeline.
- Drives the freeze and ld_inst_halt controls of the LD pipeline register and the fetch/decode front end.
- Detects RAW hazards between decode sources and in-flight destinations, and holds the pipeline during multi-cycle data-memory writes.
- Sequences halt: drains the pipeline, then parks in HALTED.

Parameters:
ADDR_W, 6, register address width
MEM_WR_LAT, 2, data-memory write occupancy in cycles (>=1)
DRAIN_CYCLES, 3, cycles allowed for in-flight instructions to retire after halt decode (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
dec_valid  in  1  decode stage holds a valid instruction
dec_src_1  in  ADDR_W  first source register address
dec_src_2  in  ADDR_W  second source register address
dec_uses_2  in  1  instruction reads dec_src_2
dec_is_halt  in  1  decoded instruction is HALT
ld_valid  in  1  LD stage holds a valid instruction
ld_write_adr  in  ADDR_W  LD-stage destination address
ld_writes_reg  in  1  LD-stage instruction writes the register file
ex_valid  in  1  ALU stage holds a valid instruction
ex_write_adr  in  ADDR_W  ALU-stage destination address
ex_writes_reg  in  1  ALU-stage instruction writes the register file
mem_wr_req  in  1  LD-stage instruction has data_mem_write set
freeze_front  out  1  hold fetch and decode registers
freeze  out  1  hold LD and later pipeline registers
ld_inst_halt  out  1  LD register must not capture decode output
halted  out  1  core halted, registered
state  out  3  encoded FSM state: RUN=0, MEM_BUSY=1, DRAIN=2, HALTED=3
stall_cnt  out  8  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=RUN, halted=0, internal counter=0, stall_cnt=0.
  - Combinational outputs then evaluate as RUN.
- Hazard (combinational):
  - haz_ld = dec_valid & ld_valid & ld_writes_reg & (dec_src_1==ld_write_adr | dec_uses_2 & dec_src_2==ld_write_adr).
  - haz_ex is the same expression using ex_* signals.
  - haz = haz_ld | haz_ex.
- RUN, evaluated in priority order:
  - mem_wr_req & MEM_WR_LAT>1:
    - Outputs this cycle: freeze=0 (the write proceeds), freeze_front=1, ld_inst_halt=1.
    - Load counter=MEM_WR_LAT-2; next state MEM_BUSY.
  - haz:
    - freeze_front=1, ld_inst_halt=1 (bubble), freeze=0.
    - Stay in RUN; stall_cnt+1, saturating at 255.
  - dec_valid & dec_is_halt:
    - freeze_front=1, ld_inst_halt=1; HALT does not enter LD.
    - Load counter=DRAIN_CYCLES-1; next state DRAIN.
  - Otherwise: all three controls 0.
- MEM_BUSY:
  - freeze=1, freeze_front=1, ld_inst_halt=1.
  - Counter decrements each cycle; at counter==0, next state RUN.
  - Total pipeline hold is exactly MEM_WR_LAT cycles including the request cycle.
  - mem_wr_req and haz are ignored in this state.
  - dec_is_halt is held by the frozen decode stage and is re-evaluated in RUN.
- DRAIN:
  - freeze_front=1, ld_inst_halt=1, freeze=0; back stages keep advancing bubbles.
  - mem_wr_req is still honoured: freeze=1 for MEM_WR_LAT-1 extra cycles while the drain counter pauses.
  - At counter==0 (not paused), next state HALTED.
- HALTED:
  - freeze=1, freeze_front=1, ld_inst_halt=1, halted=1 (set on the HALTED entry edge).
  - Terminal; only rst_n=0 exits.
- Reset mid-operation: any state returns to RUN on the next edge; counters and halted are cleared; no partial sequence resumes.
- Address 0 has no special treatment; a match on address 0 is a hazard.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined: the ALU stage forwards to decode, so haz = haz_ld only and ALU-stage matches never stall.
- Undefined: haz = haz_ld | haz_ex as above.
- Port list is identical in both builds.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> state=0, halted=0, stall_cnt=0, freeze=freeze_front=ld_inst_halt=0.
- LD hazard: dec_valid=1, dec_src_1=5, ld_valid=1, ld_writes_reg=1, ld_write_adr=5 for 1 cycle -> freeze_front=1, ld_inst_halt=1, freeze=0 that cycle, stall_cnt=1.
- ALU hazard on src 2: dec_uses_2=1, dec_src_2=9, ex_write_adr=9, ex_valid=ex_writes_reg=1:
  - without PIPE_FWD_EN -> stall asserted;
  - with PIPE_FWD_EN -> no stall, stall_cnt unchanged.
- Memory write with MEM_WR_LAT=3: mem_wr_req=1 in RUN, with simultaneous haz=1 -> freeze_front=1 for 3 cycles, freeze=1 for cycles 2-3, state 1 for 2 cycles, then RUN; stall_cnt does not increment.
- Halt, DRAIN_CYCLES=3: dec_valid=dec_is_halt=1 -> state=2 for 3 cycles, then state=3 with halted=1; a pulse of ld_valid with a matching hazard during DRAIN causes no change.
- Reset during DRAIN (2nd cycle) -> state=0, halted stays 0; a subsequent halt re-drains the full 3 cycles.
